// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
//   start    : request a conversion (sampled only when idle)
//   bin      : WIDTH-bit unsigned value, captured on the accepted-start edge
//   busy     : conversion in progress
//   done     : one-cycle pulse when bcd/overflow are updated
//   bcd      : DIGITS packed BCD digits, units in bits [3:0]
//   overflow : value did not fit in DIGITS digits
// master = requester (drives start/bin); slave = converter.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble).
// One WIDTH-bit unsigned value becomes DIGITS packed BCD digits over
// WIDTH+1 clocks: accept edge, WIDTH shift edges, then one edge that
// publishes the result and pulses done.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   io    : bin_to_bcd_seq_if.slave (start/bin in; busy/done/bcd/overflow out)

// Per-digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decade.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    bin_to_bcd_seq_if.slave   io
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                   state, state_nxt;
    logic [WIDTH-1:0]         sreg;
    logic [DIGITS-1:0][3:0]   scratch;
    logic [DIGITS-1:0][3:0]   adj;
    logic [BW-1:0]            adj_flat;
    logic [BW-1:0]            scr_shift;
    logic                     carry_out;
    logic [CW-1:0]            cnt;
    logic                     sticky;
    logic                     done_q;
    logic                     ovf_q;
    logic [BW-1:0]            bcd_q;
    logic                     accept;
    logic                     finish;
    logic                     last;

    // All digits are corrected in parallel before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_add3 u_add3 (.d(scratch[g]), .q(adj[g]));
    end

    assign adj_flat  = adj;
    // Shift-register MSB enters the units LSB; top digit MSB falls out.
    assign scr_shift = {adj_flat[BW-2:0], sreg[WIDTH-1]};
    assign carry_out = adj_flat[BW-1];
    // cnt counts completed shifts; WIDTH means the result is ready.
    assign last      = (cnt == CW'(WIDTH));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (io.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            scratch <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            done_q <= finish;
            if (accept) begin
                sreg    <= io.bin;
                scratch <= '0;
                sticky  <= 1'b0;
                cnt     <= '0;
            end else if (state == SHIFT && !last) begin
                scratch <= scr_shift;
                sreg    <= {sreg[WIDTH-2:0], 1'b0};
                // Any bit lost off the top digit means value >= 10^DIGITS.
                sticky  <= sticky | carry_out;
                cnt     <= cnt + CW'(1);
            end
            // Results only change here, so they hold across a conversion.
            if (finish) begin
                bcd_q <= scratch;
                ovf_q <= sticky;
            end
        end
    end

    assign io.busy     = (state == SHIFT);
    assign io.done     = done_q;
    assign io.bcd      = bcd_q;
    assign io.overflow = ovf_q;
endmodule
